// File: rtl/serial_parity_checker.sv
// rtl/serial_parity_checker.sv - serial bit-stream frame assembler with running-XOR parity check
module serial_parity_checker #(
    parameter int FRAME_BITS = 8,
    parameter bit ODD_PARITY = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  bit_valid,
    input  logic                  bit_in,
    output logic                  bit_ready,
    output logic                  frame_valid,
    input  logic                  frame_ready,
    output logic [FRAME_BITS-1:0] frame_data,
    output logic                  parity_err,
    output logic [7:0]            err_count
);

    localparam int CW = $clog2(FRAME_BITS);
    localparam logic [CW-1:0] LAST = CW'(FRAME_BITS - 1);

    localparam logic [1:0] S_DATA = 2'd0;
    localparam logic [1:0] S_PAR  = 2'd1;
    localparam logic [1:0] S_OUT  = 2'd2;

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic          acc;
    logic          accept;
    logic          frame_bad;

    assign bit_ready = (state != S_OUT) & ~flush;
    assign accept    = bit_valid & bit_ready;
    assign frame_bad = acc ^ bit_in ^ ODD_PARITY;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_DATA;
            cnt         <= '0;
            acc         <= 1'b0;
            frame_valid <= 1'b0;
            frame_data  <= '0;
            parity_err  <= 1'b0;
            err_count   <= 8'h00;
        end else if (flush) begin
            // err_count deliberately survives a flush
            state       <= S_DATA;
            cnt         <= '0;
            acc         <= 1'b0;
            frame_valid <= 1'b0;
        end else begin
            case (state)
                S_DATA: begin
                    if (accept) begin
                        frame_data[cnt] <= bit_in;
                        acc             <= acc ^ bit_in;
                        if (cnt == LAST) begin
                            state <= S_PAR;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                S_PAR: begin
                    if (accept) begin
                        parity_err  <= frame_bad;
                        frame_valid <= 1'b1;
                        state       <= S_OUT;
                        if (frame_bad && (err_count != 8'hFF)) begin
                            err_count <= err_count + 8'd1;
                        end
                    end
                end
                S_OUT: begin
                    if (frame_valid && frame_ready) begin
                        frame_valid <= 1'b0;
                        cnt         <= '0;
                        acc         <= 1'b0;
                        state       <= S_DATA;
                    end
                end
                default: state <= S_DATA;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_parity_checker.sv
// tb/tb_serial_parity_checker.sv - self-checking bench for serial_parity_checker (even and odd builds)
module tb_serial_parity_checker;

    localparam int FB = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          flush;
    logic          bit_valid;
    logic          bit_in;
    logic          frame_ready;

    logic          bit_ready, frame_valid, parity_err;
    logic [FB-1:0] frame_data;
    logic [7:0]    err_count;

    logic          o_bit_ready, o_frame_valid, o_parity_err;
    logic [FB-1:0] o_frame_data;
    logic [7:0]    o_err_count;

    int n_vec = 0;
    int n_err = 0;

    serial_parity_checker #(.FRAME_BITS(FB), .ODD_PARITY(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .bit_valid(bit_valid), .bit_in(bit_in), .bit_ready(bit_ready),
        .frame_valid(frame_valid), .frame_ready(frame_ready),
        .frame_data(frame_data), .parity_err(parity_err), .err_count(err_count)
    );

    serial_parity_checker #(.FRAME_BITS(FB), .ODD_PARITY(1'b1)) dut_odd (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .bit_valid(bit_valid), .bit_in(bit_in), .bit_ready(o_bit_ready),
        .frame_valid(o_frame_valid), .frame_ready(frame_ready),
        .frame_data(o_frame_data), .parity_err(o_parity_err), .err_count(o_err_count)
    );

    always #5 clk = ~clk;

    // Frame-level model: collect FB bits, then judge the whole frame by its popcount.
    int            m_n = 0;
    logic [FB-1:0] m_word = '0;
    logic [FB-1:0] m_data = '0;
    logic          m_valid = 1'b0;
    logic          m_perr = 1'b0;
    int            m_ecnt = 0;
    int            m_ecnt_odd = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_n = 0; m_word = '0; m_data = '0; m_valid = 1'b0; m_perr = 1'b0;
            m_ecnt = 0; m_ecnt_odd = 0;
        end else if (flush) begin
            m_n = 0; m_valid = 1'b0;
        end else if (m_valid) begin
            if (frame_ready) begin
                m_valid = 1'b0;
                m_n = 0;
            end
        end else if (bit_valid) begin
            if (m_n < FB) begin
                m_word[m_n] = bit_in;
                m_n++;
            end else begin
                m_data  = m_word;
                m_perr  = ((($countones(m_word) + int'(bit_in)) % 2) == 1);
                m_valid = 1'b1;
                if (m_perr && m_ecnt < 255) m_ecnt++;
                if (!m_perr && m_ecnt_odd < 255) m_ecnt_odd++;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        check("bit_ready", 32'(bit_ready), 32'(!m_valid && !flush));
        check("frame_valid", 32'(frame_valid), 32'(m_valid));
        check("err_count", 32'(err_count), 32'(m_ecnt));
        check("odd_frame_valid", 32'(o_frame_valid), 32'(m_valid));
        check("odd_err_count", 32'(o_err_count), 32'(m_ecnt_odd));
        if (m_valid) begin
            check("frame_data", 32'(frame_data), 32'(m_data));
            check("parity_err", 32'(parity_err), 32'(m_perr));
            check("odd_frame_data", 32'(o_frame_data), 32'(m_data));
            check("odd_parity_err", 32'(o_parity_err), 32'(!m_perr));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        bit_valid = 1'b1;
        bit_in    = b;
        step();
    endtask

    task automatic send_frame(input logic [FB-1:0] d, input logic p);
        for (int i = 0; i < FB; i++) send_bit(d[i]);
        send_bit(p);
        bit_valid = 1'b0;
        bit_in    = 1'b0;
    endtask

    initial begin
        rst_n = 1'b1; flush = 1'b0; bit_valid = 1'b0; bit_in = 1'b0; frame_ready = 1'b0;
        #2 rst_n = 1'b0;
        step();
        check("rst_frame_data", 32'(frame_data), 32'h0);
        check("rst_parity_err", 32'(parity_err), 32'h0);
        rst_n = 1'b1;
        step();

        // reset mid-frame
        frame_ready = 1'b1;
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        bit_valid = 1'b0;
        rst_n = 1'b0;
        #2;
        check("midrst_frame_valid", 32'(frame_valid), 32'h0);
        check("midrst_err_count", 32'(err_count), 32'h0);
        check("midrst_bit_ready", 32'(bit_ready), 32'h1);
        step();
        rst_n = 1'b1;
        step();

        // even parity, good frame
        send_frame(8'hA5, 1'b0);
        check("a5_frame_data", 32'(frame_data), 32'hA5);
        check("a5_parity_err", 32'(parity_err), 32'h0);
        check("a5_err_count", 32'(err_count), 32'h0);
        check("a5_odd_parity_err", 32'(o_parity_err), 32'h1);
        step();
        check("a5_one_cycle", 32'(frame_valid), 32'h0);

        // bad parity
        send_frame(8'hA5, 1'b1);
        check("a5p1_parity_err", 32'(parity_err), 32'h1);
        check("a5p1_err_count", 32'(err_count), 32'h1);
        check("a5p1_odd_parity_err", 32'(o_parity_err), 32'h0);
        step();

        // back-pressure
        frame_ready = 1'b0;
        send_frame(8'h3C, 1'b0);
        for (int i = 0; i < 5; i++) begin
            bit_valid = 1'b1; bit_in = 1'b1;
            step();
            check("bp_bit_ready", 32'(bit_ready), 32'h0);
            check("bp_frame_data", 32'(frame_data), 32'h3C);
            check("bp_frame_valid", 32'(frame_valid), 32'h1);
        end
        frame_ready = 1'b1;
        step();
        check("bp_after_hs", 32'(bit_ready), 32'h1);
        send_frame(8'hC3, 1'b0);
        check("c3_frame_data", 32'(frame_data), 32'hC3);
        step();

        // flush partial frame
        send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
        flush = 1'b1; bit_valid = 1'b1; bit_in = 1'b1;
        step();
        flush = 1'b0; bit_valid = 1'b0;
        step();
        send_frame(8'h0F, 1'b0);
        check("0f_frame_data", 32'(frame_data), 32'h0F);
        check("0f_parity_err", 32'(parity_err), 32'h0);
        step();

        // flush a pending frame
        frame_ready = 1'b0;
        send_frame(8'h55, 1'b1);
        check("55_pending", 32'(frame_valid), 32'h1);
        flush = 1'b1; frame_ready = 1'b1;
        step();
        flush = 1'b0;
        check("55_flushed", 32'(frame_valid), 32'h0);
        check("55_errcnt_kept", 32'(err_count), 32'h2);
        step();

        // saturation
        for (int f = 0; f < 260; f++) begin
            send_frame(8'h00, 1'b1);
            check("sat_parity_err", 32'(parity_err), 32'h1);
            step();
        end
        check("sat_err_count", 32'(err_count), 32'hFF);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
